// File: rtl/pll_lock_monitor.sv
// Frequency-lock monitor: measures PLL output clock cycles per reference oscillator period
// and compares the measurement against the programmed feedback ratio.
module pll_lock_monitor #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TOL      = 1,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             osc,
  input  logic [4:0]       div,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             osc_lost
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StArm  = 2'd1;
  localparam logic [1:0] StMeas = 2'd2;
  localparam logic [1:0] StLost = 2'd3;

  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   Tol     = (CNT_W+1)'(TOL);
  localparam logic [3:0]       LockCnt = 4'(LOCK_CNT);

  logic             sync1, sync2, sync3;
  logic             osc_edge;
  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [3:0]       match_cnt;
  logic [3:0]       match_inc;
  logic [CNT_W:0]   count_ext;
  logic [CNT_W:0]   div_ext;
  logic [CNT_W:0]   diff;
  logic             match;

  // Synchroniser runs regardless of enable so an edge is never invented on re-enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= osc;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign osc_edge = sync2 & ~sync3;

  always_comb begin
    count_ext = {1'b0, count};
    div_ext   = (CNT_W+1)'(div);
    if (count_ext >= div_ext) begin
      diff = count_ext - div_ext;
    end else begin
      diff = div_ext - count_ext;
    end
    // div of 0 or 1 is not a usable ratio, so nothing may ever match it
    match     = (div >= 5'd2) && (diff <= Tol);
    match_inc = (match_cnt >= LockCnt) ? LockCnt : match_cnt + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      state        <= StIdle;
      count        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      osc_lost     <= 1'b0;
      match_cnt    <= 4'd0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        StIdle: begin
          state <= StArm;
        end
        StArm: begin
          if (osc_edge) begin
            count <= {{(CNT_W-1){1'b0}}, 1'b1};
            state <= StMeas;
          end
        end
        StMeas: begin
          // An edge on the saturating cycle still counts as a valid (maximal) period.
          if (osc_edge) begin
            period       <= count;
            period_valid <= 1'b1;
            count        <= {{(CNT_W-1){1'b0}}, 1'b1};
            if (match) begin
              match_cnt <= match_inc;
              locked    <= (match_inc == LockCnt);
            end else begin
              match_cnt <= 4'd0;
              locked    <= 1'b0;
            end
          end else if (count == CntMax) begin
            state     <= StLost;
            osc_lost  <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= 4'd0;
          end else begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        StLost: begin
          if (osc_edge) begin
            count    <= {{(CNT_W-1){1'b0}}, 1'b1};
            osc_lost <= 1'b0;
            state    <= StMeas;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: osc periods driven in clock units, expected
// period/lock results queued on each osc rise and compared when period_valid pulses.
module tb_pll_lock_monitor;

  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             osc;
  logic [4:0]       div;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             osc_lost;

  int n_assert = 0;
  int n_fail   = 0;

  int exp_period_q[$];
  bit exp_lock_q[$];
  bit armed;
  int last_p;
  int mcnt;
  int ep;
  bit el;

  pll_lock_monitor #(
    .CNT_W(CNT_W),
    .TOL(1),
    .LOCK_CNT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .osc(osc),
    .div(div),
    .period(period),
    .period_valid(period_valid),
    .locked(locked),
    .osc_lost(osc_lost)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_period"}, 32'(period), 32'd0);
    check({tag, "_valid"}, 32'(period_valid), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_osc_lost"}, 32'(osc_lost), 32'd0);
  endtask

  // Expected outcome of the period that the current osc rise closes.
  task automatic push_expect();
    int  d;
    bit  m;
    d = last_p - int'(div);
    if (d < 0) d = -d;
    m = (div >= 5'd2) && (d <= 1);
    if (m) mcnt = (mcnt >= 4) ? 4 : mcnt + 1;
    else mcnt = 0;
    exp_period_q.push_back(last_p);
    exp_lock_q.push_back(mcnt == 4);
  endtask

  // One osc period of p clocks, rising on the first negedge.
  task automatic osc_cycle(input int p);
    for (int i = 0; i < p; i++) begin
      @(negedge clock);
      if (i == 0) begin
        osc = 1'b1;
        if (armed) push_expect();
        armed  = 1'b1;
        last_p = p;
      end else if (i == p / 2) begin
        osc = 1'b0;
      end
    end
  endtask

  always @(negedge clock) begin
    if (period_valid) begin
      check("sb_pending", 32'(exp_period_q.size() != 0), 32'd1);
      if (exp_period_q.size() != 0) begin
        ep = exp_period_q.pop_front();
        el = exp_lock_q.pop_front();
        check("period", 32'(period), 32'(ep));
        check("locked_at_valid", 32'(locked), 32'(el));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    osc    = 1'b0;
    div    = 5'd8;
    armed  = 1'b0;
    mcnt   = 0;
    last_p = 0;
    repeat (3) @(negedge clock);
    check_cleared("reset");
    reset  = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clock);

    // Nominal lock at period 8, div 8
    for (int k = 0; k < 7; k++) osc_cycle(8);
    check("lock_nominal", 32'(locked), 32'd1);

    // Period jumps to 11: drops lock; relock only once div follows
    osc_cycle(11);
    osc_cycle(11);
    check("unlock_on_11", 32'(locked), 32'd0);
    div = 5'd11;
    for (int k = 0; k < 4; k++) osc_cycle(11);
    check("relock_div11", 32'(locked), 32'd1);
    osc_cycle(11);

    // Jitter within tolerance keeps matching; 10 against 8 does not
    div = 5'd8;
    osc_cycle(9);
    osc_cycle(7);
    osc_cycle(9);
    osc_cycle(7);
    osc_cycle(9);
    check("lock_jitter", 32'(locked), 32'd1);
    osc_cycle(10);
    osc_cycle(10);
    check("unlock_10", 32'(locked), 32'd0);
    osc_cycle(10);
    check("stay_unlocked_10", 32'(locked), 32'd0);
    for (int k = 0; k < 5; k++) osc_cycle(8);
    check("relock_8", 32'(locked), 32'd1);

    // Edge on the saturation cycle is still a period of 255
    osc_cycle(255);
    osc_cycle(8);
    check("sat_period", 32'(period), 32'd255);
    check("sat_no_lost", 32'(osc_lost), 32'd0);
    check("sat_unlocked", 32'(locked), 32'd0);
    for (int k = 0; k < 5; k++) osc_cycle(8);
    check("relock_after_sat", 32'(locked), 32'd1);

    // Oscillator stops: lost exactly after the counter saturates
    osc_cycle(8);
    repeat (250) @(negedge clock);
    check("lost_not_yet", 32'(osc_lost), 32'd0);
    @(negedge clock);
    check("lost_set", 32'(osc_lost), 32'd1);
    check("lost_unlocked", 32'(locked), 32'd0);
    armed = 1'b0;
    mcnt  = 0;
    osc_cycle(8);
    check("lost_cleared", 32'(osc_lost), 32'd0);
    for (int k = 0; k < 5; k++) osc_cycle(8);
    check("relock_after_lost", 32'(locked), 32'd1);

    // Reset mid-period while locked
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_cleared("midreset");
    armed = 1'b0;
    mcnt  = 0;
    @(negedge clock);
    for (int k = 0; k < 6; k++) osc_cycle(8);
    check("relock_after_reset", 32'(locked), 32'd1);

    // Disable while locked, then an invalid ratio
    @(negedge clock);
    enable = 1'b0;
    div    = 5'd1;
    repeat (3) @(negedge clock);
    check_cleared("disable");
    enable = 1'b1;
    armed  = 1'b0;
    mcnt   = 0;
    @(negedge clock);
    for (int k = 0; k < 6; k++) osc_cycle(8);
    check("div1_never_locks", 32'(locked), 32'd0);

    repeat (8) @(negedge clock);
    check("sb_drained", 32'(exp_period_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
